mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Main control state machine for the multicycle MIPS core. Sequences every instruction through fetch, decode, execute, memory and writeback states, and drives the write-enable inputs of the core's enable-gated state registers (PC, IR, register file, memory). It also drives the datapath mux selects and the ALU operation class. Memory accesses use a request/ready handshake so the core tolerates multi-cycle memory.

## Interface
- `OP_RTYPE`, 6'h00: R-type opcode.
- `OP_LW`, 6'h23: load word.
- `OP_SW`, 6'h2B: store word.
- `OP_BEQ`, 6'h04: branch if equal.
- `OP_ADDI`, 6'h08: add immediate (only with `MC_CTRL_ADDI_EN`).
- `OP_J`, 6'h02: jump.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; sampled only in DECODE.
- `zero` in 1: ALU zero flag; used only in BEQEX.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: access is a write.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: IR enable.
- `pc_en` out 1: PC enable; `pc_en = pc_write | (branch & zero)`.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 1: destination select; 0 = rt, 1 = rd.
- `mem_to_reg` out 1: writeback select; 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = A.
- `alu_src_b` out 2: ALU B select; 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = decode funct.
- `pc_src` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` out 4: current state code, for debug and verification.

## Operation
- State register is 4 bits, reset asynchronously to RESET. Outputs decode from `state`, plus `mem_ready` and `zero` where noted. Any output not listed for a state is 0.
- RESET (0): all outputs 0. Next state FETCH unconditionally.
- FETCH (1):
  - Outputs: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write` and `pc_write` are asserted only while `mem_ready`=1.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE (2):
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut).
  - Next state: lw/sw → MEMADR; R → RTYPEEX; beq → BEQEX; addi → ADDIEX; j → JEX.
  - Any other opcode → FETCH with `illegal_op`=1 for this cycle.
- MEMADR (3): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state MEMRD for lw, MEMWR for sw.
  - The opcode is held in IR, and IR is not rewritten until FETCH, so MEMADR may use `opcode` directly.
- MEMRD (4): `mem_req`=1, `iord`=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB (5): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next state FETCH.
- MEMWR (6): `mem_req`=1, `mem_write`=1, `iord`=1. Wait for `mem_ready`, then go to FETCH.
- RTYPEEX (7): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state RTYPEWB.
- RTYPEWB (8): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next state FETCH.
- BEQEX (9): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `branch`=1, so `pc_en`=`zero`. Next state FETCH.
- ADDIEX (10): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state ADDIWB.
- ADDIWB (11): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next state FETCH.
- JEX (12): `pc_src`=10, `pc_write`=1. Next state FETCH.
- Codes 13-15 are unreachable. If entered, the FSM goes to FETCH next cycle with all outputs 0.

## Timing
- Reset value: `state`=0 and every output 0, immediately on `reset_n` falling, independent of `clk`.
- The first FETCH is the first rising edge after `reset_n` rises.
- Asserting reset mid-instruction aborts it. Partial results are discarded and no further enables are issued.
- Latency with `mem_ready` tied to 1, counted FETCH to next FETCH:
  - lw 5 cycles
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each cycle of `mem_ready`=0 adds one cycle in FETCH, MEMRD or MEMWR.
- `mem_req` and `mem_write` stay stable while waiting. `ir_write`, `pc_write` and `reg_write` never assert during a wait cycle.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- `zero` affects `pc_en` combinationally, in BEQEX only.
- `illegal_op` is a pulse, exactly one cycle per offending instruction.

## Configuration
- `MC_CTRL_ADDI_EN` defined: the ADDIEX/ADDIWB path exists and opcode `OP_ADDI` executes in 4 cycles.
- `MC_CTRL_ADDI_EN` undefined: states 10 and 11 are not generated. `OP_ADDI` is treated as illegal (`illegal_op` pulse, return to FETCH, no `reg_write`).

## Test plan
- Reset: drive `reset_n`=0 mid-MEMRD → `state`=0 and all outputs 0 at once. Release → FETCH on the next edge, then `ir_write`=`pc_en`=1 with `mem_ready`=1.
- lw, `mem_ready`=1: state sequence 1,2,3,4,5,1. `reg_write`=1 with `mem_to_reg`=1 only in state 5.
- sw with `mem_ready` low for 3 cycles in MEMWR: `mem_req`=`mem_write`=`iord`=1 held for 4 cycles, then FETCH. `reg_write` never asserts.
- beq: `zero`=1 → `pc_en`=1 with `pc_src`=01 in BEQEX. `zero`=0 → `pc_en`=0. Both return to FETCH after 3 cycles.
- R-type then j: `alu_op`=10 in RTYPEEX, then `reg_write`=1 with `reg_dst`=1. j gives `pc_src`=10 and `pc_en`=1 in JEX.
- Opcode 6'h3F, then addi (6'h08) in both builds:
  - 6'h3F → one-cycle `illegal_op`, back to FETCH.
  - addi with `MC_CTRL_ADDI_EN` → states 10, 11.
  - addi without it → `illegal_op`=1 and no `reg_write`.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// master = FSM side (drives enables/selects), slave = datapath/memory side.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode,
        input  zero,
        input  mem_ready,
        output mem_req,
        output mem_write,
        output iord,
        output ir_write,
        output pc_en,
        output reg_write,
        output reg_dst,
        output mem_to_reg,
        output alu_src_a,
        output alu_src_b,
        output alu_op,
        output pc_src,
        output illegal_op,
        output state
    );

    modport slave (
        output opcode,
        output zero,
        output mem_ready,
        input  mem_req,
        input  mem_write,
        input  iord,
        input  ir_write,
        input  pc_en,
        input  reg_write,
        input  reg_dst,
        input  mem_to_reg,
        input  alu_src_a,
        input  alu_src_b,
        input  alu_op,
        input  pc_src,
        input  illegal_op,
        input  state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle MIPS core: fetch/decode/execute/mem/writeback sequencing.
// Define MC_CTRL_ADDI_EN to build the ADDIEX/ADDIWB path; otherwise addi decodes as illegal.
module mc_control_fsm (
    input  logic              clk,
    input  logic              reset_n,
    mc_control_fsm_if.master  bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [3:0] StReset   = 4'd0;
    localparam logic [3:0] StFetch   = 4'd1;
    localparam logic [3:0] StDecode  = 4'd2;
    localparam logic [3:0] StMemAdr  = 4'd3;
    localparam logic [3:0] StMemRd   = 4'd4;
    localparam logic [3:0] StMemWb   = 4'd5;
    localparam logic [3:0] StMemWr   = 4'd6;
    localparam logic [3:0] StRtypeEx = 4'd7;
    localparam logic [3:0] StRtypeWb = 4'd8;
    localparam logic [3:0] StBeqEx   = 4'd9;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [3:0] StAddiEx  = 4'd10;
    localparam logic [3:0] StAddiWb  = 4'd11;
`endif
    localparam logic [3:0] StJEx     = 4'd12;

    logic [3:0] r_state;
    logic [3:0] w_state_next;

    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_iord;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_illegal_op;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StReset;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StFetch;
        case (r_state)
            StReset:  w_state_next = StFetch;
            StFetch:  w_state_next = bus.mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_state_next = StMemAdr;
                    OP_RTYPE:     w_state_next = StRtypeEx;
                    OP_BEQ:       w_state_next = StBeqEx;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      w_state_next = StAddiEx;
`endif
                    OP_J:         w_state_next = StJEx;
                    default:      w_state_next = StFetch;
                endcase
            end
            // IR is frozen until the next FETCH, so opcode is still valid here.
            StMemAdr:  w_state_next = (bus.opcode == OP_SW) ? StMemWr : StMemRd;
            StMemRd:   w_state_next = bus.mem_ready ? StMemWb : StMemRd;
            StMemWb:   w_state_next = StFetch;
            StMemWr:   w_state_next = bus.mem_ready ? StFetch : StMemWr;
            StRtypeEx: w_state_next = StRtypeWb;
            StRtypeWb: w_state_next = StFetch;
            StBeqEx:   w_state_next = StFetch;
`ifdef MC_CTRL_ADDI_EN
            StAddiEx:  w_state_next = StAddiWb;
            StAddiWb:  w_state_next = StFetch;
`endif
            StJEx:     w_state_next = StFetch;
            default:   w_state_next = StFetch;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_pc_src     = 2'b00;
        w_illegal_op = 1'b0;
        case (r_state)
            StFetch: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = 2'b01;
                // Enables only on the completing cycle so wait cycles have no side effects.
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            StDecode: begin
                w_alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: w_illegal_op = 1'b0;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI: w_illegal_op = 1'b0;
`endif
                    default: w_illegal_op = 1'b1;
                endcase
            end
            StMemAdr: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            StMemRd: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            StMemWb: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            StMemWr: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            StRtypeEx: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            StRtypeWb: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            StBeqEx: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b01;
                w_pc_src    = 2'b01;
                w_branch    = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            StAddiEx: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            StAddiWb: begin
                w_reg_write = 1'b1;
            end
`endif
            StJEx: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
                w_mem_req = 1'b0;
            end
        endcase
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_write  = w_mem_write;
    assign bus.iord       = w_iord;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_en      = w_pc_write | (w_branch & bus.zero);
    assign bus.reg_write  = w_reg_write;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.pc_src     = w_pc_src;
    assign bus.illegal_op = w_illegal_op;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, reset abort, and random instruction streams.
// Honours MC_CTRL_ADDI_EN the same way the design does.
module tb_mc_control_fsm;

    logic clk = 1'b0;
    logic reset_n;

    mc_control_fsm_if bus ();

    mc_control_fsm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic       z;
        logic [3:0] st;
        logic       pc_en;
        logic       reg_wr;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic       z;
        logic [3:0] st;
        logic       ill;
    } cyc_t;

    vec_t vecs[$];
    cyc_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [15:0] dut_out;
    assign dut_out = {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_en,
                      bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                      bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op};

    // Expected output word for one cycle, written straight from the per-state output list.
    function automatic logic [15:0] spec_out(logic [3:0] st, logic rdy, logic z, logic ill);
        logic mreq = 0, mwr = 0, iord = 0, irw = 0, pcen = 0, rw = 0, rdst = 0, m2r = 0;
        logic sa = 0, il = 0;
        logic [1:0] sb = 0, aop = 0, psrc = 0;
        case (st)
            4'd1:  begin mreq = 1; sb = 2'b01; irw = rdy; pcen = rdy; end
            4'd2:  begin sb = 2'b11; il = ill; end
            4'd3:  begin sa = 1; sb = 2'b10; end
            4'd4:  begin mreq = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mreq = 1; mwr = 1; iord = 1; end
            4'd7:  begin sa = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rdst = 1; end
            4'd9:  begin sa = 1; aop = 2'b01; psrc = 2'b01; pcen = z; end
            4'd10: begin sa = 1; sb = 2'b10; end
            4'd11: begin rw = 1; end
            4'd12: begin psrc = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {mreq, mwr, iord, irw, pcen, rw, rdst, m2r, sa, sb, aop, psrc, il};
    endfunction

    // Instruction class: 0 R, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, -1 illegal.
    function automatic int op_kind(logic [5:0] op);
        case (op)
            6'h00: return 0;
            6'h23: return 1;
            6'h2B: return 2;
            6'h04: return 3;
`ifdef MC_CTRL_ADDI_EN
            6'h08: return 4;
`endif
            6'h02: return 5;
            default: return -1;
        endcase
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(logic [5:0] op, logic rdy, logic z);
        @(negedge clk);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        bus.zero      = z;
        #1;
    endtask

    task automatic run_cycle(cyc_t c);
        drive(c.op, c.rdy, c.z);
        check("state", {12'h0, bus.state}, {12'h0, c.st});
        check("outputs", dut_out, spec_out(c.st, c.rdy, c.z, c.ill));
    endtask

    task automatic push(logic [5:0] op, logic [3:0] st, logic rdy, logic z, logic ill);
        cyc_t c;
        c.op = op; c.st = st; c.rdy = rdy; c.z = z; c.ill = ill;
        q.push_back(c);
    endtask

    // Expand one instruction into its expected cycle-by-cycle trace.
    task automatic add_instr(logic [5:0] op, int fw, int mw, logic z);
        int k = op_kind(op);
        for (int i = 0; i < fw; i++) push(op, 4'd1, 1'b0, 1'($urandom), 1'b0);
        push(op, 4'd1, 1'b1, 1'($urandom), 1'b0);
        push(op, 4'd2, 1'($urandom), 1'($urandom), k < 0);
        case (k)
            1: begin
                push(op, 4'd3, 1'($urandom), 1'($urandom), 1'b0);
                for (int i = 0; i < mw; i++) push(op, 4'd4, 1'b0, 1'($urandom), 1'b0);
                push(op, 4'd4, 1'b1, 1'($urandom), 1'b0);
                push(op, 4'd5, 1'($urandom), 1'($urandom), 1'b0);
            end
            2: begin
                push(op, 4'd3, 1'($urandom), 1'($urandom), 1'b0);
                for (int i = 0; i < mw; i++) push(op, 4'd6, 1'b0, 1'($urandom), 1'b0);
                push(op, 4'd6, 1'b1, 1'($urandom), 1'b0);
            end
            0: begin
                push(op, 4'd7, 1'($urandom), 1'($urandom), 1'b0);
                push(op, 4'd8, 1'($urandom), 1'($urandom), 1'b0);
            end
            3: push(op, 4'd9, 1'($urandom), z, 1'b0);
            4: begin
                push(op, 4'd10, 1'($urandom), 1'($urandom), 1'b0);
                push(op, 4'd11, 1'($urandom), 1'($urandom), 1'b0);
            end
            5: push(op, 4'd12, 1'($urandom), 1'($urandom), 1'b0);
            default: ;
        endcase
    endtask

    function automatic vec_t mk(logic [5:0] op, logic rdy, logic z, logic [3:0] st,
                                logic pc_en, logic reg_wr, logic ill);
        vec_t v;
        v.op = op; v.rdy = rdy; v.z = z; v.st = st;
        v.pc_en = pc_en; v.reg_wr = reg_wr; v.ill = ill;
        return v;
    endfunction

    initial begin
        logic [5:0] ops [7];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};

        // Back-to-back instructions, mem_ready high; each starts with FETCH.
        vecs.push_back(mk(6'h23, 1, 0, 4'd1, 1, 0, 0));
        vecs.push_back(mk(6'h23, 1, 0, 4'd2, 0, 0, 0));
        vecs.push_back(mk(6'h23, 1, 0, 4'd3, 0, 0, 0));
        vecs.push_back(mk(6'h23, 1, 0, 4'd4, 0, 0, 0));
        vecs.push_back(mk(6'h23, 1, 0, 4'd5, 0, 1, 0));
        vecs.push_back(mk(6'h04, 1, 1, 4'd1, 1, 0, 0));
        vecs.push_back(mk(6'h04, 1, 1, 4'd2, 0, 0, 0));
        vecs.push_back(mk(6'h04, 1, 1, 4'd9, 1, 0, 0));
        vecs.push_back(mk(6'h04, 1, 0, 4'd1, 1, 0, 0));
        vecs.push_back(mk(6'h04, 1, 0, 4'd2, 0, 0, 0));
        vecs.push_back(mk(6'h04, 1, 0, 4'd9, 0, 0, 0));
        vecs.push_back(mk(6'h00, 1, 0, 4'd1, 1, 0, 0));
        vecs.push_back(mk(6'h00, 1, 0, 4'd2, 0, 0, 0));
        vecs.push_back(mk(6'h00, 1, 0, 4'd7, 0, 0, 0));
        vecs.push_back(mk(6'h00, 1, 0, 4'd8, 0, 1, 0));
        vecs.push_back(mk(6'h02, 1, 0, 4'd1, 1, 0, 0));
        vecs.push_back(mk(6'h02, 1, 0, 4'd2, 0, 0, 0));
        vecs.push_back(mk(6'h02, 1, 0, 4'd12, 1, 0, 0));
        vecs.push_back(mk(6'h3F, 1, 0, 4'd1, 1, 0, 0));
        vecs.push_back(mk(6'h3F, 1, 0, 4'd2, 0, 0, 1));
        vecs.push_back(mk(6'h08, 1, 0, 4'd1, 1, 0, 0));
`ifdef MC_CTRL_ADDI_EN
        vecs.push_back(mk(6'h08, 1, 0, 4'd2, 0, 0, 0));
        vecs.push_back(mk(6'h08, 1, 0, 4'd10, 0, 0, 0));
        vecs.push_back(mk(6'h08, 1, 0, 4'd11, 0, 1, 0));
`else
        vecs.push_back(mk(6'h08, 1, 0, 4'd2, 0, 0, 1));
`endif
        vecs.push_back(mk(6'h2B, 1, 0, 4'd1, 1, 0, 0));
        vecs.push_back(mk(6'h2B, 1, 0, 4'd2, 0, 0, 0));
        vecs.push_back(mk(6'h2B, 1, 0, 4'd3, 0, 0, 0));
        vecs.push_back(mk(6'h2B, 1, 0, 4'd6, 0, 0, 0));

        reset_n       = 1'b0;
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        #1;
        check("reset_state", {12'h0, bus.state}, 16'h0);
        check("reset_outputs", dut_out, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].rdy, vecs[i].z);
            check("vec_state", {12'h0, bus.state}, {12'h0, vecs[i].st});
            check("vec_outputs", dut_out,
                  spec_out(vecs[i].st, vecs[i].rdy, vecs[i].z, vecs[i].ill));
            check("vec_pc_en", {15'h0, bus.pc_en}, {15'h0, vecs[i].pc_en});
            check("vec_reg_write", {15'h0, bus.reg_write}, {15'h0, vecs[i].reg_wr});
            check("vec_illegal", {15'h0, bus.illegal_op}, {15'h0, vecs[i].ill});
        end

        // lw stalled in MEMRD, then reset asserted mid-cycle.
        push(6'h23, 4'd1, 1'b1, 1'b0, 1'b0);
        push(6'h23, 4'd2, 1'b1, 1'b0, 1'b0);
        push(6'h23, 4'd3, 1'b0, 1'b0, 1'b0);
        push(6'h23, 4'd4, 1'b0, 1'b0, 1'b0);
        while (q.size() > 0) run_cycle(q.pop_front());
        #2 reset_n = 1'b0;
        #1;
        check("abort_state", {12'h0, bus.state}, 16'h0);
        check("abort_outputs", dut_out, 16'h0);
        @(posedge clk);
        #1;
        check("abort_hold_state", {12'h0, bus.state}, 16'h0);
        check("abort_hold_outputs", dut_out, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // sw held 3 cycles in MEMWR, then a random instruction stream.
        add_instr(6'h2B, 0, 3, 1'b0);
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end
        while (q.size() > 0) run_cycle(q.pop_front());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
